booth_seq_divider: RTL and testbench

- Sequential signed integer divider; the inverse-direction companion to the team's Booth sequential multiplier.
- Sits in the same arithmetic unit and shares its start/done handshake style.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands using one restoring-division iteration per clock.
- Controller FSM and datapath (remainder register, quotient shift register, magnitude/sign logic, iteration counter) live in one module.

---
 rtl/booth_seq_divider.sv | 124 ++++++++++++
 tb/tb_booth_seq_divider.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/booth_seq_divider.sv
// Sequential signed restoring divider: one quotient bit per clock, start/done handshake.
// Quotient truncates toward zero; remainder carries the sign of the dividend.
module booth_seq_divider #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] dd_r;
  logic [WIDTH-1:0] ds_r;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] abs_ds;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] abs_dd_in;
  logic [WIDTH-1:0] abs_ds_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // Magnitudes as unsigned WIDTH-bit values; the most negative operand maps to 2^(WIDTH-1).
  assign abs_dd_in = dd_r[WIDTH-1] ? -dd_r : dd_r;
  assign abs_ds_in = ds_r[WIDTH-1] ? -ds_r : ds_r;

  // {R,Q} shifted left: the next dividend-magnitude bit leaves Q and enters R.
  assign rem_sh = (rem_r << 1) | {{WIDTH{1'b0}}, quo_r[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, abs_ds};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: all state, including the datapath registers, uses non-blocking assignments
  // and a synchronous reset so that a reset mid-operation discards the partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dd_r        <= '0;
      ds_r        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      abs_ds      <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dd_r  <= dividend;
            ds_r  <= divisor;
            state <= LOAD;
          end
        end
        LOAD: begin
          sign_q      <= dd_r[WIDTH-1] ^ ds_r[WIDTH-1];
          sign_r      <= dd_r[WIDTH-1];
          abs_ds      <= abs_ds_in;
          quo_r       <= abs_dd_in;
          rem_r       <= '0;
          cnt         <= '0;
          overflow    <= 1'b0;
          div_by_zero <= 1'b0;
          if (ds_r == '0) begin
            // Results are published here so they are already valid in DONE.
            quotient    <= '1;
            remainder   <= dd_r;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          if (!trial[WIDTH]) begin
            rem_r <= trial;
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= rem_sh;
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IT) state <= FIX;
        end
        FIX: begin
          // Negating the quotient magnitude 2^(WIDTH-1) wraps to MOST_NEG, the defined overflow result.
          quotient  <= sign_q ? -quo_r : quo_r;
          remainder <= sign_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
          overflow  <= (dd_r == MOST_NEG) && (ds_r == '1);
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed-vector bench for booth_seq_divider (WIDTH=5) with hand-computed results.
module tb_booth_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] dividend;
  logic [4:0] divisor;
  logic [4:0] quotient;
  logic [4:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  booth_seq_divider #(.WIDTH(5), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one operation at edge 0 and follow it to done; samples on falling edges.
  task automatic do_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] eq, input logic [4:0] er,
                       input logic ez, input logic eo, input int elat);
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, " busy_c1"}, 32'(busy), 32'd1);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(elat));
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    check({tag, " busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    check({tag, " q_hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    int ndone;
    int first_done;
    int second_done;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quotient", 32'(quotient), 32'd0);
    check("rst remainder", 32'(remainder), 32'd0);
    check("rst flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;

    do_op("13/3",   5'b01101, 5'b00011, 5'b00100, 5'b00001, 1'b0, 1'b0, 8);
    do_op("-13/3",  5'b10011, 5'b00011, 5'b11100, 5'b11111, 1'b0, 1'b0, 8);
    do_op("13/-3",  5'b01101, 5'b11101, 5'b11100, 5'b00001, 1'b0, 1'b0, 8);
    do_op("7/0",    5'b00111, 5'b00000, 5'b11111, 5'b00111, 1'b1, 1'b0, 2);
    do_op("6/2",    5'b00110, 5'b00010, 5'b00011, 5'b00000, 1'b0, 1'b0, 8);
    do_op("-16/-1", 5'b10000, 5'b11111, 5'b10000, 5'b00000, 1'b0, 1'b1, 8);
    do_op("-16/1",  5'b10000, 5'b00001, 5'b10000, 5'b00000, 1'b0, 1'b0, 8);

    // Start while busy and operand changes mid-operation must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 5'b01101; divisor = 5'b00011;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin start = 1'b1; dividend = 5'b01001; divisor = 5'b00010; end
      if (c == 4) begin start = 1'b0; dividend = 5'b11111; divisor = 5'b00000; end
      if (done) begin
        ndone++;
        check("ignore quotient", 32'(quotient), 32'd4);
        check("ignore remainder", 32'(remainder), 32'd1);
        check("ignore latency", 32'(c), 32'd8);
      end
    end
    check("ignore done_count", 32'(ndone), 32'd1);

    // Start held high re-triggers with one IDLE cycle between operations.
    @(negedge clk);
    start = 1'b1; dividend = 5'b01101; divisor = 5'b00011;
    @(posedge clk);
    ndone = 0; first_done = 0; second_done = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) first_done = c;
        if (ndone == 2) second_done = c;
      end
      if (c == 18) start = 1'b0;
    end
    check("held done_count", 32'(ndone), 32'd2);
    check("held spacing", 32'(second_done - first_done), 32'd9);
    check("held quotient", 32'(quotient), 32'd4);

    // Reset in cycle 4 aborts the operation.
    @(negedge clk);
    start = 1'b1; dividend = 5'b01101; divisor = 5'b00011;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);

    do_op("2/5", 5'b00010, 5'b00101, 5'b00000, 5'b00010, 1'b0, 1'b0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
